div_restoring_32: RTL and testbench

DIV_RESTORING_32 -- requirements
Module: div_restoring_32

---
 rtl/div_pkg.sv | 15 +
 rtl/ADDSUB_32.sv | 18 +
 rtl/div_restoring_32.sv | 104 ++++++++++
 tb/tb_div_restoring_32.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the 32-bit restoring divider: state encoding,
// data width and iteration count.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ADDSUB_32.sv
// 32-bit adder/subtractor. With Sub=1 it computes A - B as A + ~B + 1, so
// Cout=1 means the subtraction did not borrow.
module ADDSUB_32
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff     = B ^ {WIDTH{Sub}};
  assign {Cout, S} = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Sub};

endmodule

// File: rtl/div_restoring_32.sv
// Unsigned 32-bit restoring divider, one quotient bit per clock. Busy and
// Done are registered copies of the previous state, so they trail it by a cycle.
module div_restoring_32
  import div_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] quo_w;
  logic [WIDTH-1:0] dvs_w;
  logic             dz_w;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_next;
  logic             cout;
  logic             take;
  logic             accept;

  // The remainder MSB shifted out acts as the 33rd bit: when set, the true
  // shifted value is >= 2^32 > Y, so the subtraction always succeeds.
  assign shifted  = {rem_w[WIDTH-2:0], quo_w[WIDTH-1]};
  assign take     = rem_w[WIDTH-1] | cout;
  assign rem_next = take ? diff : shifted;
  assign accept   = Start && (state != RUN);

  ADDSUB_32 u_addsub (
    .A    (shifted),
    .B    (dvs_w),
    .Sub  (1'b1),
    .S    (diff),
    .Cout (cout)
  );

  // NOTE: every register here uses non-blocking assignment so all of them
  // sample pre-edge values; the accept block relies on overriding the case.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem_w   <= '0;
      quo_w   <= '0;
      dvs_w   <= '0;
      dz_w    <= 1'b0;
      Q       <= '0;
      R       <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Busy <= (state == RUN);
      Done <= (state == DONE);

      unique case (state)
        IDLE: ;
        RUN: begin
          rem_w <= rem_next;
          quo_w <= {quo_w[WIDTH-2:0], take};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITERS - 1)) state <= DONE;
        end
        DONE: begin
          Q       <= quo_w;
          R       <= rem_w;
          DivZero <= dz_w;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new request overrides the DONE->IDLE move; the result above still
      // lands in Q/R because it reads the pre-edge working registers.
      if (accept) begin
        dvs_w <= Y;
        cnt   <= '0;
        if (state == IDLE) DivZero <= 1'b0;
        if (Y == '0) begin
          quo_w <= '1;
          rem_w <= X;
          dz_w  <= 1'b1;
          state <= DONE;
        end else begin
          quo_w <= X;
          rem_w <= '0;
          dz_w  <= 1'b0;
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_restoring_32.sv
// Self-checking bench for div_restoring_32: directed vector table, multi-cycle
// corner sequences (ignored Start, mid-run reset, back-to-back) and a random
// reconstruction loop.
module tb_div_restoring_32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  div_restoring_32 dut (
    .Clk     (clk),
    .Rst     (rst),
    .Start   (start),
    .X       (x),
    .Y       (y),
    .Q       (q),
    .R       (r),
    .Busy    (busy),
    .Done    (done),
    .DivZero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives a request for the next rising edge and releases Start after it.
  task automatic start_op(input logic [31:0] xv, input logic [31:0] yv);
    x = xv;
    y = yv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // n counts rising edges since acceptance; Busy is compared every cycle.
  task automatic wait_done(input int base, input bit busy_exp, output int n, output int busy_bad);
    n = base;
    busy_bad = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== (busy_exp && n >= 1 && n <= 32)) busy_bad++;
      if (n >= base + 60) break;
      @(posedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int bb;
    int done_seen;
    logic [31:0] xv;
    logic [31:0] yv;
    longint unsigned recon;

    vecs[0]  = '{32'd136,        32'd17,         32'd8,          32'd0,        1'b0};
    vecs[1]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,        1'b0};
    vecs[2]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,        1'b0};
    vecs[3]  = '{32'd5,          32'd9,          32'd0,          32'd5,        1'b0};
    vecs[4]  = '{32'd7,          32'd0,          32'hFFFF_FFFF,  32'd7,        1'b1};
    vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,        1'b0};
    vecs[6]  = '{32'd100,        32'd7,          32'd14,         32'd2,        1'b0};
    vecs[7]  = '{32'd1000,       32'd3,          32'd333,        32'd1,        1'b0};
    vecs[8]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,        1'b0};
    vecs[9]  = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,        1'b0};
    vecs[10] = '{32'd12345678,   32'd10000,      32'd1234,       32'd5678,     1'b0};
    vecs[11] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,        1'b1};
    vecs[12] = '{32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  32'h0000_FFFF, 1'b0};

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #2 check("reset_state", {q, r, busy, done, div_zero}, 96'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      start_op(vecs[i].x, vecs[i].y);
      wait_done(0, vecs[i].y != 0, n, bb);
      check($sformatf("v%0d_latency", i), n, (vecs[i].y == 0) ? 1 : 33);
      check($sformatf("v%0d_busy", i), bb, 0);
      check($sformatf("v%0d_q", i), q, vecs[i].q);
      check($sformatf("v%0d_r", i), r, vecs[i].r);
      check($sformatf("v%0d_dz", i), div_zero, vecs[i].dz);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 1'b0);
      check($sformatf("v%0d_hold", i), {q, r}, {vecs[i].q, vecs[i].r});
    end

    // Start during RUN is ignored; operand changes after acceptance do nothing.
    @(negedge clk);
    start_op(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start_op(32'd1, 32'd1);
    x = '0;
    y = '0;
    wait_done(10, 1'b1, n, bb);
    check("ignored_latency", n, 33);
    check("ignored_busy", bb, 0);
    check("ignored_qr", {q, r}, {32'd14, 32'd2});
    @(negedge clk);
    check("ignored_no_rerun", {busy, done}, 2'b00);

    // Reset mid-run: outputs clear at once and no Done follows.
    @(negedge clk);
    start_op(32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 check("rst_async_clear", {q, r, busy, done, div_zero}, 96'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("rst_no_done", done_seen, 0);
    start_op(32'd1000, 32'd3);
    wait_done(0, 1'b1, n, bb);
    check("post_rst_latency", n, 33);
    check("post_rst_qr", {q, r}, {32'd333, 32'd1});

    // Start coincident with Done starts the next division immediately.
    start_op(32'd77, 32'd0);
    wait_done(0, 1'b0, n, bb);
    check("b2b_dz_latency", n, 1);
    check("b2b_dz_result", {q, r, div_zero}, {32'hFFFF_FFFF, 32'd77, 1'b1});
    start_op(32'd50, 32'd8);
    wait_done(0, 1'b1, n, bb);
    check("b2b_latency", n, 33);
    check("b2b_result", {q, r, div_zero}, {32'd6, 32'd2, 1'b0});

    // Random pairs, issued back-to-back on each Done.
    for (int i = 0; i < 1000; i++) begin
      xv = $urandom;
      yv = $urandom;
      case (i % 6)
        0: yv = 32'd1;
        1: begin xv = xv | 32'd1; yv = xv; end
        2: begin xv = $urandom_range(0, 32'hFFFF_FFF0); yv = xv + 32'd1 + $urandom_range(0, 14); end
        3: xv = 32'hFFFF_FFFF;
        4: yv = 32'hFFFF_FFFF;
        default: yv = yv >> $urandom_range(0, 31);
      endcase
      if (yv == 0) yv = 32'd1;
      start_op(xv, yv);
      wait_done(0, 1'b1, n, bb);
      recon = longint'(q) * longint'(yv) + longint'(r);
      check($sformatf("rand%0d_recon", i), recon, {32'd0, xv});
      check($sformatf("rand%0d_r_lt_y", i), r < yv, 1'b1);
      check($sformatf("rand%0d_latency", i), n, 33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
